// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver assembling 66-bit command words (optional UART_CMD_CKSUM_EN checksum byte)
module uart_cmd_rx #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [65:0] cmd,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC);

`ifdef UART_CMD_CKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
    localparam int         AB_W     = 64;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam int         AB_W     = 56;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             cnt_clr;
    logic             sample_bit;
    logic             byte_stb;
    logic             stop_err;
    logic             timeout;
    logic [3:0]       byte_idx;
    logic [1:0]       op_stage;
    logic [AB_W-1:0]  ab_stage;
    logic [GAP_W-1:0] gap_cnt;
`ifdef UART_CMD_CKSUM_EN
    logic [7:0]       cksum;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Bit FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Bit FSM next state and per-cycle strobes
    always_comb begin
        state_n    = state;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        byte_stb   = 1'b0;
        stop_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (bit_cnt == CNT_MID) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    sample_bit = 1'b1;
                    cnt_clr    = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    state_n  = IDLE;
                    byte_stb = rx_s;
                    stop_err = !rx_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bit timing counter, data bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            rx_byte <= 8'h00;
        end else begin
            if (cnt_clr || state == IDLE) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == START) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_bit) begin
                rx_byte <= {rx_s, rx_byte[7:1]};
            end
        end
    end

    assign timeout = (byte_idx != 4'd0) && (gap_cnt == GAP_LIMIT);

    // Frame assembly, inter-byte timeout and command publication
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx  <= 4'd0;
            op_stage  <= 2'b00;
            ab_stage  <= '0;
            gap_cnt   <= '0;
            cmd       <= 66'd0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_CMD_CKSUM_EN
            cksum     <= 8'h00;
`endif
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (byte_idx == 4'd0 || byte_stb) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            // Timeout and a bad stop bit share one error pulse
            if (timeout || stop_err) begin
                byte_idx  <= 4'd0;
                frame_err <= 1'b1;
            end else if (byte_stb) begin
                if (byte_idx == LAST_IDX) begin
                    byte_idx <= 4'd0;
`ifdef UART_CMD_CKSUM_EN
                    if (rx_byte == cksum) begin
                        cmd       <= {op_stage, ab_stage};
                        cmd_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
`else
                    cmd       <= {op_stage, ab_stage, rx_byte};
                    cmd_valid <= 1'b1;
`endif
                end else begin
                    byte_idx <= byte_idx + 4'd1;
                    if (byte_idx == 4'd0) begin
                        op_stage <= rx_byte[1:0];
                    end else begin
                        ab_stage <= {ab_stage[AB_W-9:0], rx_byte};
                    end
`ifdef UART_CMD_CKSUM_EN
                    cksum <= (byte_idx == 4'd0) ? rx_byte : (cksum ^ rx_byte);
`endif
                end
            end
        end
    end

    assign busy = (state != IDLE) || (byte_idx != 4'd0);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - randomized self-checking bench for uart_cmd_rx
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    localparam int  CLK_HZ      = 100_000_000;
    localparam int  BAUD        = 6_250_000;
    localparam int  TIMEOUT_CYC = 5000;
    localparam real BIT_NS      = 160.0;
`ifdef UART_CMD_CKSUM_EN
    localparam int  NB = 10;
`else
    localparam int  NB = 9;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [65:0] cmd;
    logic        cmd_valid;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_wide = 0;
    int n_hold = 0;
    logic [65:0] cmd_q[$];
    logic [65:0] prev_cmd;
    logic        prev_valid = 1'b0;
    logic        prev_err = 1'b0;
    logic [7:0]  fr[0:9];

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    // Pulse monitor: counts pulses, captures commands, flags wide pulses and unannounced cmd changes
    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid++;
            cmd_q.push_back(cmd);
        end
        if (frame_err) n_err++;
        if ((cmd_valid && prev_valid) || (frame_err && prev_err)) n_wide++;
        if (!rst && !cmd_valid && (prev_cmd !== cmd)) n_hold++;
        prev_cmd   = cmd;
        prev_valid = cmd_valid;
        prev_err   = frame_err;
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        if (good_stop) begin
            rx = 1'b1;
            #(bit_ns);
        end else begin
            rx = 1'b0;
            #(bit_ns * 0.75);
            rx = 1'b1;
            #(bit_ns * 0.25);
        end
    endtask

    task automatic send_frame(input real bit_ns, input int gap_cyc);
        for (int i = 0; i < NB; i++) begin
            send_byte(fr[i], 1'b1, bit_ns);
            if (gap_cyc > 0) repeat (gap_cyc) @(negedge clk);
        end
    endtask

    task automatic load(input logic [71:0] bytes);
        for (int i = 0; i < 9; i++) fr[i] = bytes[71-8*i -: 8];
        fr[9] = 8'h00;
        for (int i = 0; i < 9; i++) fr[9] = fr[9] ^ fr[i];
    endtask

    task automatic load_random();
        logic [71:0] r;
        r[71:64] = 8'($urandom);
        r[63:32] = $urandom;
        r[31:0]  = $urandom;
        load(r);
    endtask

    // Reference: op is byte 0 bits [1:0], operands are big-endian byte groups
    function automatic logic [65:0] model_cmd();
        logic [31:0] a;
        logic [31:0] b;
        a = 32'd0;
        b = 32'd0;
        for (int i = 1; i <= 4; i++) a = a * 256 + 32'(fr[i]);
        for (int i = 5; i <= 8; i++) b = b * 256 + 32'(fr[i]);
        return {fr[0][1:0], a, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd !== 66'd0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", cmd); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_good_frame();
        int v0;
        int e0;
        logic [65:0] exp_cmd;
        v0 = n_valid;
        e0 = n_err;
        cmd_q.delete();
        load(72'h02_40_40_00_00_40_00_00_00);
        exp_cmd = model_cmd();
        send_frame(BIT_NS, 0);
        repeat (20) @(negedge clk);
        checks++; if (n_valid != v0 + 1) begin errors++; $display("FAIL good_valid_count: got %0d expected %0d", n_valid - v0, 1); end
        checks++; if (cmd !== exp_cmd) begin errors++; $display("FAIL good_cmd: got %h expected %h", cmd, exp_cmd); end
        checks++; if (cmd_q.size() != 1 || cmd_q[0] !== exp_cmd) begin errors++; $display("FAIL good_cmd_at_pulse: got %0d pulses expected %h", cmd_q.size(), exp_cmd); end
        checks++; if (n_err != e0) begin errors++; $display("FAIL good_no_err: got %0d expected 0", n_err - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [65:0] exp_a;
        logic [65:0] exp_b;
        int h0;
        h0 = n_hold;
        cmd_q.delete();
        load_random();
        exp_a = model_cmd();
        send_frame(BIT_NS, 0);
        load(72'h02_3F_00_00_00_3F_00_00_00);
        exp_b = model_cmd();
        send_frame(BIT_NS, 0);
        repeat (20) @(negedge clk);
        checks++; if (cmd_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", cmd_q.size()); end
        checks++; if (cmd_q.size() < 1 || cmd_q[0] !== exp_a) begin errors++; $display("FAIL b2b_first: got %h expected %h", (cmd_q.size() > 0) ? cmd_q[0] : 66'hx, exp_a); end
        checks++; if (cmd !== exp_b) begin errors++; $display("FAIL b2b_second: got %h expected %h", cmd, exp_b); end
        checks++; if (n_hold != h0) begin errors++; $display("FAIL b2b_hold: got %0d unannounced cmd changes expected 0", n_hold - h0); end
    endtask

    task automatic test_glitch();
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (n_valid != v0 || n_err != e0) begin errors++; $display("FAIL glitch_pulses: got valid %0d err %0d expected 0 0", n_valid - v0, n_err - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    endtask

    task automatic test_bad_stop();
        int v0;
        int e0;
        logic [65:0] exp_cmd;
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h02, 1'b1, BIT_NS);
        send_byte(8'h40, 1'b1, BIT_NS);
        send_byte(8'($urandom), 1'b0, BIT_NS);
        repeat (40) @(negedge clk);
        checks++; if (n_err != e0 + 1) begin errors++; $display("FAIL badstop_err: got %0d expected 1", n_err - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badstop_busy: got %b expected 0", busy); end
        checks++; if (n_valid != v0) begin errors++; $display("FAIL badstop_valid: got %0d expected 0", n_valid - v0); end
        load_random();
        exp_cmd = model_cmd();
        send_frame(BIT_NS, 0);
        repeat (20) @(negedge clk);
        checks++; if (n_valid != v0 + 1 || cmd !== exp_cmd) begin errors++; $display("FAIL badstop_recover: got %h expected %h", cmd, exp_cmd); end
    endtask

    task automatic test_random();
        logic [65:0] exp_cmd;
        real bit_ns;
        int w0;
        w0 = n_wide;
        for (int f = 0; f < 6; f++) begin
            cmd_q.delete();
            load_random();
            exp_cmd = model_cmd();
            case ($urandom_range(0, 2))
                0: bit_ns = BIT_NS * 0.98;
                1: bit_ns = BIT_NS * 1.02;
                default: bit_ns = BIT_NS;
            endcase
            send_frame(bit_ns, int'($urandom_range(0, 3)));
            repeat (int'($urandom_range(20, 60))) @(negedge clk);
            checks++; if (cmd_q.size() != 1 || cmd_q[0] !== exp_cmd) begin errors++; $display("FAIL random_frame%0d: got %0d pulses cmd %h expected %h", f, cmd_q.size(), cmd, exp_cmd); end
        end
        checks++; if (n_wide != w0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", n_wide - w0); end
    endtask

    task automatic test_timeout_reset();
        int e0;
        int v0;
        int cyc;
        logic [65:0] exp_cmd;
        e0 = n_err;
        load_random();
        for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b1, BIT_NS);
        cyc = 0;
        while (n_err == e0 && cyc < TIMEOUT_CYC + 1000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc < TIMEOUT_CYC - 30 || cyc > TIMEOUT_CYC + 10) begin errors++; $display("FAIL timeout_delay: got %0d cycles expected about %0d", cyc, TIMEOUT_CYC); end
        repeat (10) @(negedge clk);
        checks++; if (n_err != e0 + 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", n_err - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end

        e0 = n_err;
        v0 = n_valid;
        load_random();
        for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b1, BIT_NS);
        fork
            send_byte(fr[3], 1'b1, BIT_NS);
            begin
                #(BIT_NS * 4.5);
                rst = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd !== 66'd0 || cmd_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got cmd %h valid %b err %b busy %b expected all 0", cmd, cmd_valid, frame_err, busy); end
        checks++; if (n_err != e0 || n_valid != v0) begin errors++; $display("FAIL midreset_pulses: got err %0d valid %0d expected 0 0", n_err - e0, n_valid - v0); end
        load_random();
        exp_cmd = model_cmd();
        send_frame(BIT_NS, 0);
        repeat (20) @(negedge clk);
        checks++; if (cmd !== exp_cmd) begin errors++; $display("FAIL midreset_resume: got %h expected %h", cmd, exp_cmd); end
    endtask

`ifdef UART_CMD_CKSUM_EN
    task automatic test_cksum();
        int e0;
        int v0;
        logic [65:0] exp_cmd;
        load(72'h02_40_00_00_00_BF_80_00_00);
        exp_cmd = model_cmd();
        v0 = n_valid;
        send_frame(BIT_NS, 0);
        repeat (20) @(negedge clk);
        checks++; if (n_valid != v0 + 1 || cmd !== exp_cmd) begin errors++; $display("FAIL cksum_good: got %h expected %h", cmd, exp_cmd); end
        fr[9] = fr[9] ^ 8'h01;
        e0 = n_err;
        v0 = n_valid;
        send_frame(BIT_NS, 0);
        repeat (20) @(negedge clk);
        checks++; if (n_err != e0 + 1) begin errors++; $display("FAIL cksum_bad_err: got %0d expected 1", n_err - e0); end
        checks++; if (n_valid != v0 || cmd !== exp_cmd) begin errors++; $display("FAIL cksum_bad_hold: got %h expected %h", cmd, exp_cmd); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_glitch();
        test_bad_stop();
        test_random();
        test_timeout_reset();
`ifdef UART_CMD_CKSUM_EN
        test_cksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
